hdmi_vram_port_a_bridge: RTL
============================

// Module: hdmi_vram_port_a_bridge
// PURPOSE
//  Sits between the AXI4-Lite slave of the HDMI text controller and VRAM BRAM port A.
//  Turns one latched register access into a timed BRAM access that respects BRAM read
//  latency, applies byte strobes, and hosts the 8-entry colour palette.
//  Returns one response per request; the AXI slave issues a new request only after it.
// PARAMETERS
//  C_S_AXI_DATA_WIDTH  32    data width (bits); strobe width = /8
//  VRAM_WORDS          1200  VRAM depth in words (80x30 chars, 2 chars/word)
//  VRAM_ADDR_WIDTH     11    BRAM port A word-address width
//  BRAM_RD_LATENCY     2     cycles from bram_ena (read) to valid bram_douta, >=1
//  PALETTE_BASE        12'h800  word address of palette entry 0 (8 entries)
// PORTS
//  S_AXI_ACLK     in   1    clock
//  S_AXI_ARESETN  in   1    async active-low reset
//  req_valid      in   1    request present (sampled only when req_ready=1)
//  req_ready      out  1    bridge idle, can accept
//  req_we         in   1    1=write, 0=read
//  req_addr       in   12   word address
//  req_wdata      in   32   write data
//  req_wstrb      in   4    byte enables (write only)
//  rsp_valid      out  1    one-cycle response pulse
//  rsp_rdata      out  32   read data (0 for writes/errors)
//  rsp_err        out  1    1=address decode error (SLVERR)
//  bram_ena       out  1    BRAM port A enable
//  bram_wea       out  4    BRAM port A byte write enables
//  bram_addra     out  11   BRAM port A address
//  bram_dina      out  32   BRAM port A write data
//  bram_douta     in   32   BRAM port A read data
//  pal_rd_idx     in   3    palette index from pixel pipeline
//  pal_rd_data    out  32   palette entry, registered
// BEHAVIOUR
//  Reset (async, immediate): state=IDLE, req_ready=1, rsp_valid=0, rsp_rdata=0,
//   rsp_err=0, bram_ena=0, bram_wea=0, bram_addra=0, bram_dina=0, palette all 0,
//   pal_rd_data=0. Reset mid-access aborts it; no response is ever produced for it.
//  Decode: addr<VRAM_WORDS -> VRAM; PALETTE_BASE..+7 -> palette; else error.
//  FSM: IDLE -> {WRITE | RD_WAIT | RESP} -> ... -> RESP -> IDLE. req_ready=1 only in IDLE.
//  Accept at cycle T (req_valid & req_ready): latch we/addr/wdata/wstrb.
//  VRAM write: T+1 state WRITE, bram_ena=1, bram_wea=req_wstrb, addra/dina driven;
//   T+2 RESP: rsp_valid=1, rsp_err=0, rsp_rdata=0. wstrb=0 -> ena=1, wea=0, still responds.
//  VRAM read: T+1 issue (ena=1, wea=0, addra); counter waits BRAM_RD_LATENCY cycles;
//   douta captured at end of cycle T+1+LAT-... i.e. rsp_valid at T+2+BRAM_RD_LATENCY
//   (T+4 for default) with rsp_rdata = BRAM word at addr.
//  Palette write: bytes with wstrb=1 updated at end of T+1; rsp_valid at T+2.
//  Palette read: rsp_valid at T+2, rsp_rdata = entry value.
//  Error: no BRAM/palette activity (ena=0); rsp_valid at T+2, rsp_err=1, rsp_rdata=0.
//  bram_ena/bram_wea high exactly one cycle per VRAM access; 0 otherwise.
//  RESP lasts one cycle; IDLE next cycle, so back-to-back accepts are >=3 cycles apart.
//  rsp_rdata/rsp_err hold value until next RESP; only rsp_valid pulses.
//  Palette read port: pal_rd_data <= palette[pal_rd_idx] every cycle, 1-cycle latency,
//   independent of FSM; same-cycle write to same entry returns old value, new next cycle.
//  req_valid outside IDLE is ignored (no queuing).
// TESTING
//  Reset, write addr 0x005 data 0xDEADBEEF strb 4'hF -> T+1 ena=1 wea=F addra=5; rsp T+2 err=0.
//  Read addr 0x005 (LAT=2) -> one ena pulse at T+1, rsp_valid at T+4, rdata=0xDEADBEEF.
//  Write 0x11223344 strb 4'b0101 over 0xDEADBEEF at 0x005 -> readback 0xDE22BE44.
//  Write palette 0x803 = 0x00F0A0B0, pal_rd_idx=3 -> pal_rd_data 0x00F0A0B0 from next cycle.
//  Read addr 0x4B0 (=1200) and 0x808 -> no ena, rsp T+2 err=1 rdata=0.
//  Assert S_AXI_ARESETN low during RD_WAIT -> outputs reset at once, no rsp_valid, req_ready=1.

Source files
------------

// File: rtl/hdmi_vram_port_a_bridge.sv
// Register-access bridge from the HDMI text AXI slave to VRAM BRAM port A,
// with the 8-entry colour palette and its pixel-side read port.
module hdmi_vram_port_a_bridge #(
   parameter int          C_S_AXI_DATA_WIDTH = 32,
   parameter int          VRAM_WORDS         = 1200,
   parameter int          VRAM_ADDR_WIDTH    = 11,
   parameter int          BRAM_RD_LATENCY    = 2,
   parameter logic [11:0] PALETTE_BASE       = 12'h800
) (
   input  logic                              S_AXI_ACLK,
   input  logic                              S_AXI_ARESETN,
   input  logic                              req_valid,
   output logic                              req_ready,
   input  logic                              req_we,
   input  logic [11:0]                       req_addr,
   input  logic [C_S_AXI_DATA_WIDTH-1:0]     req_wdata,
   input  logic [C_S_AXI_DATA_WIDTH/8-1:0]   req_wstrb,
   output logic                              rsp_valid,
   output logic [C_S_AXI_DATA_WIDTH-1:0]     rsp_rdata,
   output logic                              rsp_err,
   output logic                              bram_ena,
   output logic [C_S_AXI_DATA_WIDTH/8-1:0]   bram_wea,
   output logic [VRAM_ADDR_WIDTH-1:0]        bram_addra,
   output logic [C_S_AXI_DATA_WIDTH-1:0]     bram_dina,
   input  logic [C_S_AXI_DATA_WIDTH-1:0]     bram_douta,
   input  logic [2:0]                        pal_rd_idx,
   output logic [C_S_AXI_DATA_WIDTH-1:0]     pal_rd_data
);

   localparam int DW = C_S_AXI_DATA_WIDTH;
   localparam int SW = DW / 8;
   localparam int CW = $clog2(BRAM_RD_LATENCY + 1);

   localparam logic [2:0] S_IDLE    = 3'd0;
   localparam logic [2:0] S_WRITE   = 3'd1;
   localparam logic [2:0] S_RD_WAIT = 3'd2;
   localparam logic [2:0] S_LOCAL   = 3'd3;
   localparam logic [2:0] S_RESP    = 3'd4;

   logic [2:0]                 state_q, state_d;
   logic [CW-1:0]              cnt_q, cnt_d;
   logic                       we_q, we_d;
   logic                       pal_hit_q, pal_hit_d;
   logic [2:0]                 pidx_q, pidx_d;
   logic [DW-1:0]              wdata_q, wdata_d;
   logic [SW-1:0]              wstrb_q, wstrb_d;
   logic                       ena_q, ena_d;
   logic [SW-1:0]              wea_q, wea_d;
   logic [VRAM_ADDR_WIDTH-1:0] addra_q, addra_d;
   logic [DW-1:0]              dina_q, dina_d;
   logic [DW-1:0]              rdata_q, rdata_d;
   logic                       err_q, err_d;
   logic [DW-1:0]              pal_q [8];
   logic [DW-1:0]              pal_rd_q;
   logic                       pal_we;

   logic        hit_vram;
   logic        hit_pal;
   logic [12:0] pal_end;

   assign pal_end  = {1'b0, PALETTE_BASE} + 13'd8;
   assign hit_vram = {1'b0, req_addr} < 13'(VRAM_WORDS);
   assign hit_pal  = ({1'b0, req_addr} >= {1'b0, PALETTE_BASE})
                   && ({1'b0, req_addr} < pal_end);

   always_comb begin
      state_d   = state_q;
      cnt_d     = cnt_q;
      we_d      = we_q;
      pal_hit_d = pal_hit_q;
      pidx_d    = pidx_q;
      wdata_d   = wdata_q;
      wstrb_d   = wstrb_q;
      ena_d     = 1'b0;
      wea_d     = '0;
      addra_d   = addra_q;
      dina_d    = dina_q;
      rdata_d   = rdata_q;
      err_d     = err_q;
      pal_we    = 1'b0;
      unique case (state_q)
         S_IDLE: begin
            if (req_valid) begin
               we_d      = req_we;
               wdata_d   = req_wdata;
               wstrb_d   = req_wstrb;
               pal_hit_d = hit_pal & ~hit_vram;
               pidx_d    = req_addr[2:0] - PALETTE_BASE[2:0];
               cnt_d     = '0;
               if (hit_vram) begin
                  ena_d   = 1'b1;
                  wea_d   = req_we ? req_wstrb : '0;
                  addra_d = req_addr[VRAM_ADDR_WIDTH-1:0];
                  dina_d  = req_wdata;
                  state_d = req_we ? S_WRITE : S_RD_WAIT;
               end else begin
                  state_d = S_LOCAL;
               end
            end
         end
         S_WRITE: begin
            rdata_d = '0;
            err_d   = 1'b0;
            state_d = S_RESP;
         end
         S_RD_WAIT: begin
            // douta is valid in the cycle where the count reaches the latency
            if (cnt_q == CW'(BRAM_RD_LATENCY)) begin
               rdata_d = bram_douta;
               err_d   = 1'b0;
               state_d = S_RESP;
            end else begin
               cnt_d = cnt_q + CW'(1);
            end
         end
         S_LOCAL: begin
            if (pal_hit_q) begin
               err_d   = 1'b0;
               rdata_d = we_q ? '0 : pal_q[pidx_q];
               pal_we  = we_q;
            end else begin
               err_d   = 1'b1;
               rdata_d = '0;
            end
            state_d = S_RESP;
         end
         S_RESP:  state_d = S_IDLE;
         default: state_d = S_IDLE;
      endcase
   end

   always_ff @(posedge S_AXI_ACLK or negedge S_AXI_ARESETN) begin
      if (!S_AXI_ARESETN) begin
         state_q   <= S_IDLE;
         cnt_q     <= '0;
         we_q      <= 1'b0;
         pal_hit_q <= 1'b0;
         pidx_q    <= '0;
         wdata_q   <= '0;
         wstrb_q   <= '0;
         ena_q     <= 1'b0;
         wea_q     <= '0;
         addra_q   <= '0;
         dina_q    <= '0;
         rdata_q   <= '0;
         err_q     <= 1'b0;
      end else begin
         state_q   <= state_d;
         cnt_q     <= cnt_d;
         we_q      <= we_d;
         pal_hit_q <= pal_hit_d;
         pidx_q    <= pidx_d;
         wdata_q   <= wdata_d;
         wstrb_q   <= wstrb_d;
         ena_q     <= ena_d;
         wea_q     <= wea_d;
         addra_q   <= addra_d;
         dina_q    <= dina_d;
         rdata_q   <= rdata_d;
         err_q     <= err_d;
      end
   end

   // Pixel-side read samples the pre-write entry on a same-cycle write
   always_ff @(posedge S_AXI_ACLK or negedge S_AXI_ARESETN) begin
      if (!S_AXI_ARESETN) begin
         for (int i = 0; i < 8; i++) pal_q[i] <= '0;
         pal_rd_q <= '0;
      end else begin
         for (int b = 0; b < SW; b++) begin
            if (pal_we && wstrb_q[b]) begin
               pal_q[pidx_q][8*b +: 8] <= wdata_q[8*b +: 8];
            end
         end
         pal_rd_q <= pal_q[pal_rd_idx];
      end
   end

   assign req_ready   = (state_q == S_IDLE);
   assign rsp_valid   = (state_q == S_RESP);
   assign rsp_rdata   = rdata_q;
   assign rsp_err     = err_q;
   assign bram_ena    = ena_q;
   assign bram_wea    = wea_q;
   assign bram_addra  = addra_q;
   assign bram_dina   = dina_q;
   assign pal_rd_data = pal_rd_q;

endmodule
